// File: rtl/niosii_system_sysid_checker_pkg.sv
// Shared types for the system-ID checker: FSM state encoding and sysid slave word addresses.
package sysid_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_ID,
    ST_WAIT_ID,
    ST_REQ_TS,
    ST_WAIT_TS,
    ST_FINISH
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/niosii_system_sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the system-ID slave.
interface niosii_system_sysid_checker_if;

  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );

endinterface

// File: rtl/niosii_system_sysid_checker_timeout.sv
// Per-read watchdog: clearable up-counter that flags expiry once it has counted TIMEOUT_CYCLES cycles.
module sysid_chk_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Hold at the limit so the counter never wraps back into a "healthy" value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/niosii_system_sysid_checker.sv
// Reads sysid word 0 (ID) and word 1 (timestamp), compares them and reports sticky pass/fail flags.
// Define SYSID_TS_CHECK_EN to make the timestamp compare contribute to ts_mismatch and pass.
module niosii_system_sysid_checker
  import sysid_chk_pkg::*;
#(
  parameter logic [31:0] EXP_ID         = 32'h0000_0000,
  parameter logic [31:0] EXP_TIMESTAMP  = 32'd1455227776,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                start,
  niosii_system_sysid_checker_if.master       avm,
  output logic                                busy,
  output logic                                done,
  output logic                                pass,
  output logic                                id_mismatch,
  output logic                                ts_mismatch,
  output logic                                timeout,
  output logic [31:0]                         id_value,
  output logic [31:0]                         ts_value
);

`ifdef SYSID_TS_CHECK_EN
  localparam logic TS_CHECK = 1'b1;
`else
  localparam logic TS_CHECK = 1'b0;
`endif

  function automatic logic word_differs(input logic [31:0] got, input logic [31:0] want);
    return (got != want);
  endfunction

  state_e      state_q, state_d;
  logic [31:0] id_q, id_d, ts_q, ts_d;
  logic        idmm_q, idmm_d, tsmm_q, tsmm_d, tmo_q, tmo_d, pass_q, pass_d;
  logic        rd_c, addr_c;
  logic        tmr_clr, tmr_inc, expired;

  // The watchdog restarts each time a new read request phase is entered.
  assign tmr_clr = (state_d != state_q) && ((state_d == ST_REQ_ID) || (state_d == ST_REQ_TS));
  assign tmr_inc = (state_q == ST_REQ_ID) || (state_q == ST_WAIT_ID) ||
                   (state_q == ST_REQ_TS) || (state_q == ST_WAIT_TS);

  sysid_chk_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock     (clock),
    .reset_n   (reset_n),
    .clr_i     (tmr_clr),
    .inc_i     (tmr_inc),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ts_d    = ts_q;
    idmm_d  = idmm_q;
    tsmm_d  = tsmm_q;
    tmo_d   = tmo_q;
    pass_d  = pass_q;
    rd_c    = 1'b0;
    addr_c  = SYSID_ADDR_ID;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idmm_d  = 1'b0;
          tsmm_d  = 1'b0;
          tmo_d   = 1'b0;
          pass_d  = 1'b0;
          state_d = ST_REQ_ID;
        end
      end
      // Expiry has priority: the request is withdrawn and the remaining read is skipped.
      ST_REQ_ID: begin
        if (expired) begin
          tmo_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          rd_c = 1'b1;
          if (!avm.avm_waitrequest) begin
            if (avm.avm_readdatavalid) begin
              id_d    = avm.avm_readdata;
              idmm_d  = word_differs(avm.avm_readdata, EXP_ID);
              state_d = ST_REQ_TS;
            end else begin
              state_d = ST_WAIT_ID;
            end
          end
        end
      end
      ST_WAIT_ID: begin
        if (expired) begin
          tmo_d   = 1'b1;
          state_d = ST_FINISH;
        end else if (avm.avm_readdatavalid) begin
          id_d    = avm.avm_readdata;
          idmm_d  = word_differs(avm.avm_readdata, EXP_ID);
          state_d = ST_REQ_TS;
        end
      end
      ST_REQ_TS: begin
        addr_c = SYSID_ADDR_TS;
        if (expired) begin
          tmo_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          rd_c = 1'b1;
          if (!avm.avm_waitrequest) begin
            if (avm.avm_readdatavalid) begin
              ts_d    = avm.avm_readdata;
              tsmm_d  = TS_CHECK & word_differs(avm.avm_readdata, EXP_TIMESTAMP);
              state_d = ST_FINISH;
            end else begin
              state_d = ST_WAIT_TS;
            end
          end
        end
      end
      ST_WAIT_TS: begin
        addr_c = SYSID_ADDR_TS;
        if (expired) begin
          tmo_d   = 1'b1;
          state_d = ST_FINISH;
        end else if (avm.avm_readdatavalid) begin
          ts_d    = avm.avm_readdata;
          tsmm_d  = TS_CHECK & word_differs(avm.avm_readdata, EXP_TIMESTAMP);
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Verdict is latched on entry to FINISH so it is already valid while done is high.
    if ((state_d == ST_FINISH) && (state_q != ST_FINISH)) begin
      pass_d = ~tmo_d & ~idmm_d & ~tsmm_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      ts_q    <= '0;
      idmm_q  <= 1'b0;
      tsmm_q  <= 1'b0;
      tmo_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      idmm_q  <= idmm_d;
      tsmm_q  <= tsmm_d;
      tmo_q   <= tmo_d;
      pass_q  <= pass_d;
    end
  end

  assign avm.avm_read    = rd_c;
  assign avm.avm_address = addr_c;
  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_FINISH);
  assign pass            = pass_q;
  assign id_mismatch     = idmm_q;
  assign ts_mismatch     = tsmm_q;
  assign timeout         = tmo_q;
  assign id_value        = id_q;
  assign ts_value        = ts_q;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Scoreboard bench for the sysid checker: a behavioural Avalon slave, a sequence-level model and a done monitor.
module tb_niosii_system_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1455227776;
  localparam int          TMO    = 12;
`ifdef SYSID_TS_CHECK_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
  logic [31:0] id_value, ts_value;

  niosii_system_sysid_checker_if bus();

  niosii_system_sysid_checker #(
    .EXP_ID         (EXP_ID),
    .EXP_TIMESTAMP  (EXP_TS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .avm         (bus),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .id_mismatch (id_mismatch),
    .ts_mismatch (ts_mismatch),
    .timeout     (timeout),
    .id_value    (id_value),
    .ts_value    (ts_value)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic        pass, idmm, tsmm, tmo;
    logic [31:0] idv, tsv;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] last_id = '0;
  logic [31:0] last_ts = '0;

  // Slave configuration, set by the stimulus process between sequences.
  logic [31:0] s_id = '0, s_ts = '0;
  int          s_wid = 0, s_wts = 0, s_lat = 1;
  bit          stray_req = 1'b0;
  int          wcnt = 0, pc = 0;
  bit          pv = 1'b0;
  logic [31:0] pd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // Avalon slave: stalls a configurable number of cycles per read, answers after s_lat cycles.
  initial begin
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata      = '0;
    forever begin
      @(negedge clock);
      bus.avm_readdatavalid = 1'b0;
      if (pv) begin
        pc--;
        if (pc == 0) begin
          pv = 1'b0;
          bus.avm_readdatavalid = 1'b1;
          bus.avm_readdata      = pd;
        end
      end
      if (stray_req) begin
        stray_req = 1'b0;
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = $urandom;
      end
      if (bus.avm_read) begin
        if (wcnt < (bus.avm_address ? s_wts : s_wid)) begin
          bus.avm_waitrequest = 1'b1;
          wcnt++;
        end else begin
          bus.avm_waitrequest = 1'b0;
          wcnt = 0;
          pd = bus.avm_address ? s_ts : s_id;
          if (s_lat == 0) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata      = pd;
          end else begin
            pv = 1'b1;
            pc = s_lat;
          end
        end
      end else begin
        bus.avm_waitrequest = 1'($urandom_range(0, 1));
        wcnt = 0;
      end
    end
  end

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n && done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, required no sequence pending", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("pass",        32'(pass),        32'(mon_e.pass));
          chk("id_mismatch", 32'(id_mismatch), 32'(mon_e.idmm));
          chk("ts_mismatch", 32'(ts_mismatch), 32'(mon_e.tsmm));
          chk("timeout",     32'(timeout),     32'(mon_e.tmo));
          chk("id_value",    id_value,         mon_e.idv);
          chk("ts_value",    ts_value,         mon_e.tsv);
          chk("start_to_done_cycles", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
        end
      end
    end
  end

  task automatic wait_drain(input int maxc);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < maxc) begin
      @(negedge clock);
      n++;
    end
    if (n >= maxc) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending after %0d cycles, required 0", sb.size(), maxc);
      sb.delete();
    end
    repeat (6) @(negedge clock);
  endtask

  // Sequence-level model: a read costs waits+1+latency cycles and aborts if that exceeds TMO.
  task automatic run_seq(input logic [31:0] id, input logic [31:0] ts, input int wid,
                         input int wts, input int lat, input bit poke_mid, input bit poke_done);
    exp_t e;
    int   cid, cts, n;
    s_id = id; s_ts = ts; s_wid = wid; s_wts = wts; s_lat = lat;
    cid = wid + 1 + lat;
    cts = wts + 1 + lat;
    e.idv = last_id; e.tsv = last_ts;
    e.tmo = 1'b0; e.idmm = 1'b0; e.tsmm = 1'b0;
    if (cid > TMO) begin
      e.tmo = 1'b1;
      e.lat = 1 + TMO + 1;
    end else begin
      e.idv  = id;
      e.idmm = (id != EXP_ID);
      if (cts > TMO) begin
        e.tmo = 1'b1;
        e.lat = 1 + cid + TMO + 1;
      end else begin
        e.tsv  = ts;
        e.tsmm = TS_ON && (ts != EXP_TS);
        e.lat  = 1 + cid + cts;
      end
    end
    e.pass  = !e.tmo && !e.idmm && !e.tsmm;
    last_id = e.idv;
    last_ts = e.tsv;

    @(negedge clock);
    start = 1'b1;
    e.t0  = cyc;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    if (poke_mid) begin
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    if (poke_done) begin
      n = 0;
      while (!done && n < 100) begin
        @(negedge clock);
        n++;
      end
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      chk("start_at_done_ignored_busy", 32'(busy), 32'd0);
    end
    wait_drain(200);
    chk("pass_sticky", 32'(pass), 32'(e.pass));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},        32'(busy),         32'd0);
    chk({tag, "_done"},        32'(done),         32'd0);
    chk({tag, "_pass"},        32'(pass),         32'd0);
    chk({tag, "_id_mismatch"}, 32'(id_mismatch),  32'd0);
    chk({tag, "_ts_mismatch"}, 32'(ts_mismatch),  32'd0);
    chk({tag, "_timeout"},     32'(timeout),      32'd0);
    chk({tag, "_id_value"},    id_value,          32'd0);
    chk({tag, "_ts_value"},    ts_value,          32'd0);
    chk({tag, "_avm_read"},    32'(bus.avm_read), 32'd0);
  endtask

  initial begin
    int t0;
    logic [31:0] rid, rts;
    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    run_seq(EXP_ID, EXP_TS, 0, 0, 1, 1'b0, 1'b0);    // matching slave, minimum latency
    run_seq(32'h1,  EXP_TS, 0, 0, 1, 1'b0, 1'b0);    // wrong ID, timestamp still read
    run_seq(EXP_ID, EXP_TS, 10, 10, 1, 1'b0, 1'b0);  // stalls that use the whole budget
    run_seq(EXP_ID, EXP_TS, 11, 0, 1, 1'b0, 1'b0);   // ID read one cycle over budget
    run_seq(EXP_ID, EXP_TS, 0, 11, 1, 1'b0, 1'b0);   // timestamp read over budget
    run_seq(EXP_ID, 32'd0, 0, 0, 0, 1'b0, 1'b0);     // zero timestamp, same-cycle response
    run_seq(EXP_ID, EXP_TS, 2, 3, 2, 1'b1, 1'b0);    // start while busy
    run_seq(32'h5,  EXP_TS, 0, 0, 1, 1'b0, 1'b1);    // start on the done cycle

    stray_req = 1'b1;
    repeat (4) @(negedge clock);
    chk("stray_rdv_busy",     32'(busy), 32'd0);
    chk("stray_rdv_id_value", id_value,  last_id);

    for (int i = 0; i < 30; i++) begin
      rid = ($urandom_range(0, 2) != 0) ? EXP_ID : $urandom;
      rts = ($urandom_range(0, 2) != 0) ? EXP_TS : $urandom;
      run_seq(rid, rts, $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 2), 1'b0, 1'b0);
    end

    // Reset during WAIT_TS with a slow slave; its late response must be ignored.
    s_id = 32'h1; s_ts = 32'h1234; s_wid = 0; s_wts = 0; s_lat = 4;
    @(negedge clock);
    start = 1'b1;
    t0 = cyc;
    @(negedge clock);
    start = 1'b0;
    while (cyc < t0 + 3) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    while (cyc < t0 + 8) @(negedge clock);
    chk("wait_ts_busy_before_reset", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clock);
    reset_n = 1'b1;
    last_id = '0;
    last_ts = '0;
    repeat (6) @(negedge clock);
    chk_all_zero("after_late_rdv");

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_empty: got %0d pending, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by %0t, required $finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
